// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the CPU control FSM:
// instruction field widths, opcode constants and the sequencer state encoding.
package instr_sequencer_pkg;

    localparam int INSTR_W = 10;
    localparam int OP_W    = 4;
    localparam int ARG_W   = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 4'h0;
    localparam logic [OP_W-1:0] OP_MOVE = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h3;
    localparam logic [OP_W-1:0] OP_NOP  = 4'hF;

    typedef enum logic [1:0] {
        SEQ_LOAD  = 2'd0,
        SEQ_READY = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_prog_ram.sv
// Program buffer: DEPTH x INSTR_W register array, one synchronous write port
// and two asynchronous read ports (current and next instruction).
module prog_ram
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr_a,
    output logic [INSTR_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0]  rd_addr_b,
    output logic [INSTR_W-1:0] rd_data_b
);

    // Contents are deliberately not reset; the sequencer's len qualifies them.
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer feeding the CPU control FSM: loads a program, then steps
// through it on each done pulse with a combinational one-word lookahead.
// Optional build macro SEQ_LOOP_EN: end-of-program wraps to address 0 instead of halting.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int              DEPTH  = 16,
    parameter int              ADDR_W = 4,
    parameter logic [OP_W-1:0] NOP_OP = OP_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    input  logic               start,
    input  logic               done,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic               running,
    output logic               halted,
    output logic [ADDR_W:0]    len
);

    localparam logic [INSTR_W-1:0] NOP_INSTR  = {NOP_OP, {(INSTR_W-OP_W){1'b0}}};
    localparam logic [ADDR_W:0]    LEN_LAST   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]    LEN_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]  PC_ONE     = ADDR_W'(1);

    seq_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W:0]     len_q, len_d;

    logic                wr_en;
    logic [ADDR_W-1:0]   pc_inc;
    logic                prog_end;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [INSTR_W-1:0]  rd_data_a, rd_data_b;

    assign wr_en    = (state_q == SEQ_LOAD) && ld_valid;
    assign pc_inc   = pc_q + PC_ONE;
    assign prog_end = ({1'b0, pc_q} == (len_q - LEN_ONE));

    // Lookahead port: next word, or address 0 when a looping program wraps.
    assign rd_addr_b = prog_end ? '0 : pc_inc;

    prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_ram (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (len_q[ADDR_W-1:0]),
        .wr_data   (ld_data),
        .rd_addr_a (pc_q),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEQ_LOAD;
            pc_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        instruction = NOP_INSTR;

        case (state_q)
            SEQ_LOAD: begin
                if (ld_valid) begin
                    len_d = len_q + LEN_ONE;
                    // A full buffer closes the program exactly like ld_last.
                    if (ld_last || (len_q == LEN_LAST)) begin
                        state_d = SEQ_READY;
                    end
                end
            end

            SEQ_READY: begin
                if (start && (len_q != '0)) begin
                    pc_d    = '0;
                    state_d = SEQ_RUN;
                end
            end

            SEQ_RUN: begin
                if (done) begin
                    if (prog_end) begin
`ifdef SEQ_LOOP_EN
                        pc_d        = '0;
                        instruction = rd_data_b;
`else
                        state_d     = SEQ_HALT;
                        instruction = NOP_INSTR;
`endif
                    end else begin
                        pc_d        = pc_inc;
                        instruction = rd_data_b;
                    end
                end else begin
                    instruction = rd_data_a;
                end
            end

            SEQ_HALT: begin
                // start has priority over a reload request.
                if (start) begin
                    pc_d    = '0;
                    state_d = SEQ_RUN;
                end else if (ld_valid) begin
                    pc_d    = '0;
                    len_d   = '0;
                    state_d = SEQ_LOAD;
                end
            end

            default: state_d = SEQ_LOAD;
        endcase
    end

    assign ld_ready = (state_q == SEQ_LOAD);
    assign running  = (state_q == SEQ_RUN);
    assign halted   = (state_q == SEQ_HALT);
    assign pc       = pc_q;
    assign len      = len_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven load/run/halt vectors
// followed by hand-written sequences for reset, full-buffer load and program end.
module tb_instr_sequencer;

    logic       clk;
    logic       rst;
    logic       ld_valid;
    logic       ld_ready;
    logic [9:0] ld_data;
    logic       ld_last;
    logic       start;
    logic       done;
    logic [9:0] instruction;
    logic [3:0] pc;
    logic       running;
    logic       halted;
    logic [4:0] len;

    int checks   = 0;
    int failures = 0;

    localparam logic [9:0] NOP = 10'h3C0;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .start       (start),
        .done        (done),
        .instruction (instruction),
        .pc          (pc),
        .running     (running),
        .halted      (halted),
        .len         (len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ldv;
        logic [9:0] ldd;
        logic       ldl;
        logic       st;
        logic       dn;
        logic [9:0] ins;
        logic [3:0] pc;
        logic       run;
        logic       hlt;
        logic [4:0] len;
        logic       rdy;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [9:0] ins, input logic [3:0] p,
                           input logic run, input logic hlt, input logic [4:0] l,
                           input logic rdy);
        chk({tag, ".instruction"}, 32'(instruction), 32'(ins));
        chk({tag, ".pc"},          32'(pc),          32'(p));
        chk({tag, ".running"},     32'(running),     32'(run));
        chk({tag, ".halted"},      32'(halted),      32'(hlt));
        chk({tag, ".len"},         32'(len),         32'(l));
        chk({tag, ".ld_ready"},    32'(ld_ready),    32'(rdy));
    endtask

    task automatic drive(input logic ldv, input logic [9:0] ldd, input logic ldl,
                         input logic st, input logic dn);
        ld_valid = ldv;
        ld_data  = ldd;
        ld_last  = ldl;
        start    = st;
        done     = dn;
    endtask

    function automatic logic [9:0] word16(input int i);
        return 10'((i * 37) + 5);
    endfunction

    initial begin
        // inputs: ldv ldd ldl st dn | expected (pre-edge): ins pc run hlt len rdy
        vecs[0]  = '{1'b1, 10'h040, 1'b0, 1'b0, 1'b0, NOP,    4'd0, 1'b0, 1'b0, 5'd0, 1'b1};
        vecs[1]  = '{1'b1, 10'h10A, 1'b0, 1'b0, 1'b0, NOP,    4'd0, 1'b0, 1'b0, 5'd1, 1'b1};
        vecs[2]  = '{1'b1, 10'h2D1, 1'b1, 1'b0, 1'b0, NOP,    4'd0, 1'b0, 1'b0, 5'd2, 1'b1};
        vecs[3]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, NOP,    4'd0, 1'b0, 1'b0, 5'd3, 1'b0};
        vecs[4]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, NOP,    4'd0, 1'b0, 1'b0, 5'd3, 1'b0};
        vecs[5]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h040, 4'd0, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[6]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h10A, 4'd0, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[7]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h10A, 4'd1, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[8]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h2D1, 4'd1, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[9]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h2D1, 4'd2, 1'b1, 1'b0, 5'd3, 1'b0};
`ifdef SEQ_LOOP_EN
        vecs[10] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h040, 4'd2, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h040, 4'd0, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[12] = '{1'b1, 10'h3FF, 1'b0, 1'b1, 1'b0, 10'h040, 4'd0, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[13] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h040, 4'd0, 1'b1, 1'b0, 5'd3, 1'b0};
`else
        vecs[10] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, NOP,    4'd2, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, NOP,    4'd2, 1'b0, 1'b1, 5'd3, 1'b0};
        vecs[12] = '{1'b1, 10'h3FF, 1'b0, 1'b1, 1'b0, NOP,    4'd2, 1'b0, 1'b1, 5'd3, 1'b0};
        vecs[13] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h040, 4'd0, 1'b1, 1'b0, 5'd3, 1'b0};
`endif

        rst = 1'b0;
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        #3;
        chk_all("reset", NOP, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].ldv, vecs[i].ldd, vecs[i].ldl, vecs[i].st, vecs[i].dn);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ins, vecs[i].pc, vecs[i].run,
                    vecs[i].hlt, vecs[i].len, vecs[i].rdy);
        end

        // Reset asserted mid-RUN at pc=1.
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("midrun.pc", 32'(pc), 32'd1);
        chk("midrun.instruction", 32'(instruction), 32'h10A);
        rst = 1'b0;
        #1;
        chk_all("rst_in_run", NOP, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Full-buffer load without ld_last.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, word16(i), 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("full%0d.ld_ready", i), 32'(ld_ready), 32'd1);
            chk($sformatf("full%0d.len", i), 32'(len), 32'(i));
        end
        @(negedge clk);
        drive(1'b1, 10'h155, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("full_ready", NOP, 4'd0, 1'b0, 1'b0, 5'd16, 1'b0);
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        #1;
        chk("full_hold.len", 32'(len), 32'd16);
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("full_run0", word16(0), 4'd0, 1'b1, 1'b0, 5'd16, 1'b0);

        // Step through all 16 words with back-to-back done pulses.
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
            #1;
            chk($sformatf("step%0d.pc", k), 32'(pc), 32'(k - 1));
            chk($sformatf("step%0d.instruction", k), 32'(instruction), 32'(word16(k)));
        end
        @(negedge clk);
        #1;
        chk("last.pc", 32'(pc), 32'd15);
`ifdef SEQ_LOOP_EN
        chk("last.instruction", 32'(instruction), 32'(word16(0)));
`else
        chk("last.instruction", 32'(instruction), 32'(NOP));
`endif
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef SEQ_LOOP_EN
        chk_all("after_last", word16(0), 4'd0, 1'b1, 1'b0, 5'd16, 1'b0);
`else
        chk_all("after_last", NOP, 4'd15, 1'b0, 1'b1, 5'd16, 1'b0);
`endif

        // Two-word program, repeated done pulses.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 10'h0C9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 10'h1D2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("two_run", 10'h0C9, 4'd0, 1'b1, 1'b0, 5'd2, 1'b0);
`ifdef SEQ_LOOP_EN
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
            #1;
            chk($sformatf("loop%0d.pc", k), 32'(pc), 32'(k % 2));
            chk($sformatf("loop%0d.instruction", k), 32'(instruction),
                (k % 2 == 0) ? 32'h1D2 : 32'h0C9);
            chk($sformatf("loop%0d.halted", k), 32'(halted), 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("loop_end", 10'h1D2, 4'd1, 1'b1, 1'b0, 5'd2, 1'b0);
`else
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
        #1;
        chk("two_d0.instruction", 32'(instruction), 32'h1D2);
        @(negedge clk);
        #1;
        chk("two_d1.pc", 32'(pc), 32'd1);
        chk("two_d1.instruction", 32'(instruction), 32'(NOP));
        @(negedge clk);
        #1;
        chk_all("two_halt_done", NOP, 4'd1, 1'b0, 1'b1, 5'd2, 1'b0);
        @(negedge clk);
        drive(1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("two_halt", NOP, 4'd1, 1'b0, 1'b1, 5'd2, 1'b0);
        @(negedge clk);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("reload", NOP, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
